// File: rtl/fft_pkg.sv
// fft_pkg: shared sequencer state encoding and FFT size helpers
package fft_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} seq_state_t;
  function automatic int half_n(input int n);
    return n / 2;
  endfunction
endpackage

// File: rtl/bf_addr_gen.sv
// bf_addr_gen: combinational butterfly index -> stage-buffer address pair and twiddle index
//   k       : butterfly index within the pass (0..N/2-1)
//   level   : butterfly level, span = 2^level
//   addr0/1 : upper/lower read addresses, addr1 = addr0 + span
//   twiddle : twiddle ROM index
module bf_addr_gen #(
  parameter int N     = 8,
  parameter int LOG_N = 3
) (
  input  logic [LOG_N-2:0] k,
  input  logic [LOG_N-1:0] level,
  output logic [LOG_N-1:0] addr0,
  output logic [LOG_N-1:0] addr1,
  output logic [LOG_N-2:0] twiddle
);
  logic [LOG_N-1:0] kx, span, pos, grp, tw;
  always_comb begin
    kx      = LOG_N'(k);
    span    = LOG_N'(1) << level;
    pos     = kx & (span - LOG_N'(1));
    grp     = kx >> level;
    addr0   = ((grp << level) << 1) | pos;
    addr1   = addr0 + span;
    tw      = pos << (LOG_N - 1 - int'(level));
    twiddle = tw[LOG_N-2:0];
  end
endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: issues the N/2 butterfly address pairs of one FFT level and counts returned results
//   start/level          : begin a pass at the given level (sampled in IDLE)
//   out_valid/out_ready  : handshake for out_addr0, out_addr1, out_twiddle, out_last
//   res_nd               : one butterfly result written back
//   busy/done/error      : pass in progress, completion pulse, sticky protocol error
module stage_sequencer
  import fft_pkg::*;
#(
  parameter int N     = 8,
  parameter int LOG_N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LOG_N-1:0] level,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOG_N-1:0] out_addr0,
  output logic [LOG_N-1:0] out_addr1,
  output logic [LOG_N-2:0] out_twiddle,
  output logic             out_last,
  input  logic             res_nd,
  output logic             busy,
  output logic             done,
  output logic             error
);
  localparam logic [LOG_N-2:0] K_LAST = (LOG_N-1)'(half_n(N) - 1);
  localparam logic [LOG_N-1:0] HALF   = LOG_N'(half_n(N));
  localparam logic [LOG_N-1:0] LMAX   = LOG_N'(LOG_N);
  seq_state_t       state;
  logic [LOG_N-2:0] k;
  logic [LOG_N-1:0] lvl, returned, a0, a1;
  logic [LOG_N-2:0] tw;
  logic             iss;
  bf_addr_gen #(.N(N), .LOG_N(LOG_N)) u_addr (
    .k(k), .level(lvl), .addr0(a0), .addr1(a1), .twiddle(tw)
  );
  // outputs decode straight from registered state so an async reset clears them at once
  assign iss         = state == ISSUE;
  assign out_valid   = iss;
  assign busy        = state != IDLE;
  assign out_addr0   = iss ? a0 : '0;
  assign out_addr1   = iss ? a1 : '0;
  assign out_twiddle = iss ? tw : '0;
  assign out_last    = iss && k == K_LAST;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      lvl      <= '0;
      returned <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && (state != IDLE || level >= LMAX)) error <= 1'b1;
      if (res_nd) begin
        if (state == IDLE || returned == HALF) error <= 1'b1;
        else returned <= returned + LOG_N'(1);
      end
      case (state)
        IDLE: if (start && level < LMAX) begin
          lvl      <= level;
          k        <= '0;
          returned <= '0;
          state    <= ISSUE;
        end
        ISSUE: if (out_ready) begin
          k     <= k + 1'b1;
          state <= k == K_LAST ? DRAIN : ISSUE;
        end
        DRAIN: if (returned == HALF) begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
